// File: rtl/mult_share_arb_pkg.sv
// mult_share_arb_pkg
//   Shared constants and types for the shared-multiplier arbiter.
//   A_W / B_W : operand widths, Y_W : product width.
//   arb_state_t : arbiter FSM encoding (also exposed on the interface for debug).
package mult_share_arb_pkg;
    localparam int A_W = 9;
    localparam int B_W = 9;
    localparam int Y_W = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;
endpackage

// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if
//   Request/response bundle between NUM_REQ requesters and the arbiter.
//   req_valid/req_ready : request handshake, req_a/req_b packed 9 bits per requester.
//   rsp_valid/rsp_ready : response handshake, rsp_y shared product.
//   state               : arbiter FSM state, observation only.
//   Handshake rule: a transfer happens on a rising clk edge where valid and
//   ready are both 1. Ready may depend on valid; valid must not depend on ready.
//   master = requester side, slave = arbiter side.
interface mult_share_arb_if #(parameter int NUM_REQ = 4);
    import mult_share_arb_pkg::*;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ-1:0]     rsp_ready;
    logic [Y_W-1:0]         rsp_y;
    arb_state_t             state;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, state
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, state
    );
endinterface

// File: rtl/mult_rr_grant.sv
// mult_rr_grant
//   Combinational winner select.
//   req_valid [NUM_REQ] in, ptr in (search start index).
//   grant_oh one-hot winner, grant_idx its index, any_valid = some request.
//   Default: round-robin, first set bit from ptr upward with wrap.
//   MULT_SHARE_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, ptr ignored.
module mult_rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_valid
);
    logic found;
    int   idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        any_valid = |req_valid;
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[k]) begin
                found       = 1'b1;
                grant_oh[k] = 1'b1;
                grant_idx   = PTR_W'(k);
            end
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = PTR_W'(idx);
            end
        end
`endif
    end
endmodule

// File: rtl/multiplier.sv
// multiplier
//   Unsigned combinational multiplier.
//   a [A_W], b [B_W] in; y [A_W+B_W] out = a*b.
module multiplier #(
    parameter int A_W = 9,
    parameter int B_W = 9
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] y
);
    assign y = a * b;
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb
//   Shares one 9x9 unsigned multiplier between NUM_REQ requesters.
//   clk, rst_n (async, active-low) plain ports; bus = mult_share_arb_if.slave.
//   IDLE grants one request (req_ready one-hot, same cycle), CALC registers the
//   product, RESP holds rsp_valid[grant] until rsp_ready[grant].
//   Optional macro MULT_SHARE_ARB_FIXED_PRIO_EN: fixed priority, ptr held at 0.
module mult_share_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_share_arb_if.slave bus
);
    import mult_share_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, grant_q, win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_any;
    logic [A_W-1:0]     op_a;
    logic [B_W-1:0]     op_b;
    logic [Y_W-1:0]     y, rsp_y_q;
    logic               rsp_hs;

    mult_rr_grant #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_grant (
        .req_valid (bus.req_valid),
        .ptr       (ptr_q),
        .grant_oh  (win_oh),
        .grant_idx (win_idx),
        .any_valid (win_any)
    );

    multiplier #(.A_W(A_W), .B_W(B_W)) u_mult (
        .a (op_a),
        .b (op_b),
        .y (y)
    );

    assign rsp_hs = (state_q == RESP) && bus.rsp_ready[grant_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_any) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. req_ready is masked while reset is asserted so no request can
    // appear accepted during reset even though the FSM already sits in IDLE.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state_q == IDLE && rst_n) bus.req_ready = win_oh;
        if (state_q == RESP)          bus.rsp_valid[grant_q] = 1'b1;
    end

    assign bus.rsp_y = rsp_y_q;
    assign bus.state = state_q;

    // Datapath: operand capture, product capture, grant and search pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            rsp_y_q <= '0;
        end else begin
            if (state_q == IDLE && win_any) begin
                op_a    <= bus.req_a[int'(win_idx)*A_W +: A_W];
                op_b    <= bus.req_b[int'(win_idx)*B_W +: B_W];
                grant_q <= win_idx;
            end
            if (state_q == CALC) rsp_y_q <= y;
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
            ptr_q <= '0;
`else
            // Next search starts just past the requester that was served.
            if (rsp_hs)
                ptr_q <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb
//   Directed and randomized bench for mult_share_arb (NUM_REQ=4).
//   Reference model: each requester holds a count of pending ops; an op takes
//   one grant cycle, one compute cycle, then waits for rsp_ready. Winner is the
//   first valid requester from the pointer; products are plain a*b.
module tb_mult_share_arb;
    import mult_share_arb_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mult_share_arb_if #(.NUM_REQ(N)) bus ();

    mult_share_arb #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Driver controls
    int         pend [N];
    logic [8:0] drv_a [N];
    logic [8:0] drv_b [N];
    logic [N-1:0] drv_rr = '1;
    logic rand_ops   = 1'b0;
    logic rand_valid = 1'b0;
    logic rand_rr    = 1'b0;

    // Reference model
    logic        m_busy;
    int          m_wait;
    int          m_win;
    int          m_ptr;
    logic [17:0] m_last_y;
    logic [17:0] exp_q [$];
    int          served_q [$];
    logic [17:0] y_log [$];
    int          hs_cyc [$];
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_pend();
        for (int i = 0; i < N; i++) if (pend[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_wait   = 0;
        m_win    = 0;
        m_ptr    = 0;
        m_last_y = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) pend[i] = 0;
    endtask

    task automatic clear_logs();
        served_q.delete();
        y_log.delete();
        hs_cyc.delete();
    endtask

    task automatic set_req(input int i, input int n, input int a, input int b);
        pend[i]  = n;
        drv_a[i] = 9'(a);
        drv_b[i] = 9'(b);
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // advance the model for the coming rising edge.
    task automatic tick();
        logic [N-1:0] v, exp_ready, exp_rv;
        arb_state_t   exp_st;
        int w;
        @(negedge clk);
        cyc++;
        if (rand_rr) drv_rr = N'($urandom_range(0, (1 << N) - 1));
        for (int i = 0; i < N; i++) begin
            v[i] = (pend[i] > 0) && (!rand_valid || ($urandom_range(0, 3) != 0));
            bus.req_valid[i]       = v[i];
            bus.req_a[i*9 +: 9]    = drv_a[i];
            bus.req_b[i*9 +: 9]    = drv_b[i];
        end
        bus.rsp_ready = drv_rr;
        #1;
        exp_ready = '0;
        exp_rv    = '0;
        w         = -1;
        if (!m_busy) begin
            exp_st = IDLE;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (w < 0 && v[idx]) w = idx;
            end
            if (w >= 0) exp_ready[w] = 1'b1;
        end else if (m_wait > 0) begin
            exp_st = CALC;
        end else begin
            exp_st = RESP;
            exp_rv[m_win] = 1'b1;
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        check("rsp_y",     32'(bus.rsp_y),     32'(m_last_y));
        check("state",     32'(bus.state),     32'(exp_st));
        if (!m_busy) begin
            if (w >= 0) begin
                m_busy = 1'b1;
                m_wait = 1;
                m_win  = w;
                exp_q.push_back(18'(drv_a[w]) * 18'(drv_b[w]));
                pend[w]--;
                if (rand_ops) begin
                    drv_a[w] = 9'($urandom_range(0, 511));
                    drv_b[w] = 9'($urandom_range(0, 511));
                end
            end
        end else if (m_wait > 0) begin
            m_wait   = 0;
            m_last_y = exp_q[0];
        end else if (drv_rr[m_win]) begin
            served_q.push_back(m_win);
            y_log.push_back(exp_q.pop_front());
            hs_cyc.push_back(cyc);
            m_busy = 1'b0;
`ifndef MULT_SHARE_ARB_FIXED_PRIO_EN
            m_ptr = (m_win + 1) % N;
`endif
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_busy || any_pend()) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(m_busy || any_pend()), 32'd0);
    endtask

    // Assert reset at a negedge and check the outputs clear at once.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '1;
        model_reset();
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_y",     32'(bus.rsp_y),     32'd0);
        check("rst_state",     32'(bus.state),     32'(IDLE));
        @(negedge clk);
        #1;
        check("rst_hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        bus.req_valid = '0;
    endtask

    initial begin
        int total;
        for (int i = 0; i < N; i++) begin
            drv_a[i] = '0;
            drv_b[i] = '0;
        end
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        model_reset();
        #3;
        do_reset();

        // Single op 2*2 on requester 0
        clear_logs();
        set_req(0, 1, 2, 2);
        drv_rr = '1;
        drain(20);
        check("single_count", 32'(served_q.size()), 32'd1);
        if (served_q.size() == 1) begin
            check("single_who", 32'(served_q[0]), 32'd0);
            check("single_y",   32'(y_log[0]),    32'd4);
        end

        // Contention from reset: all four valid, a=i+1, b=3
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) set_req(i, 1, i + 1, 3);
        drain(40);
        check("cont_count", 32'(served_q.size()), 32'd4);
        if (served_q.size() == 4) begin
            for (int i = 0; i < N; i++) begin
                check("cont_order", 32'(served_q[i]), 32'(i));
                check("cont_y",     32'(y_log[i]),    32'(3 * (i + 1)));
            end
            for (int i = 1; i < N; i++)
                check("cont_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
        end

        // Fairness: requesters 0 and 2 continuously valid
        clear_logs();
        set_req(0, 4, 1, 5);
        set_req(2, 4, 2, 5);
        drain(60);
        check("fair_count", 32'(served_q.size()), 32'd8);
        if (served_q.size() >= 4) begin
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
            for (int i = 0; i < 3; i++) check("fair_order", 32'(served_q[i]), 32'd0);
`else
            for (int i = 0; i < 4; i++) check("fair_order", 32'(served_q[i]), 32'((i % 2) * 2));
`endif
        end

        // Backpressure on requester 1 while the others wait
        clear_logs();
        set_req(1, 1, 4, 4);
        drv_rr = 4'b1101;
        tick();
        set_req(0, 1, 1, 1);
        set_req(2, 1, 1, 1);
        set_req(3, 1, 1, 1);
        tick();
        repeat (5) tick();
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
        check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        check("bp_rsp_y",     32'(bus.rsp_y),     32'd16);
        drv_rr = '1;
        drain(40);
        check("bp_count", 32'(served_q.size()), 32'd4);
        if (served_q.size() == 4) begin
            check("bp_first", 32'(served_q[0]), 32'd1);
            check("bp_y",     32'(y_log[0]),    32'd16);
        end

        // Maximum operands
        clear_logs();
        set_req(3, 1, 511, 511);
        drain(20);
        check("max_count", 32'(served_q.size()), 32'd1);
        if (served_q.size() == 1) check("max_y", 32'(y_log[0]), 32'd261121);

        // Reset while an op is in CALC; pointer moved away from 0 first
        clear_logs();
        set_req(2, 1, 5, 5);
        drain(20);
        clear_logs();
        set_req(1, 1, 3, 3);
        tick();
        check("mid_in_calc", 32'(m_busy), 32'd1);
        do_reset();
        repeat (3) tick();
        check("mid_no_rsp", 32'(served_q.size()), 32'd0);
        set_req(2, 1, 7, 9);
        set_req(3, 1, 1, 1);
        drain(30);
        check("mid_count", 32'(served_q.size()), 32'd2);
        if (served_q.size() == 2) begin
            check("mid_first", 32'(served_q[0]), 32'd2);
            check("mid_y",     32'(y_log[0]),    32'd63);
            check("mid_second", 32'(served_q[1]), 32'd3);
        end

        // Randomized traffic with random valid gaps and response stalls
        clear_logs();
        rand_ops   = 1'b1;
        rand_valid = 1'b1;
        rand_rr    = 1'b1;
        total      = 0;
        for (int i = 0; i < N; i++) begin
            set_req(i, $urandom_range(2, 8), $urandom_range(0, 511), $urandom_range(0, 511));
            total += pend[i];
        end
        drain(3000);
        check("rand_count", 32'(served_q.size()), 32'(total));
        rand_valid = 1'b0;
        rand_rr    = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one 9x9 unsigned `multiplier` instance between NUM_REQ requesters.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- A round-robin FSM grants one request at a time, registers operands, captures the 18-bit product and holds it until the winner accepts it.
- Sits between the producing datapath blocks and the shared multiplier resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  request i has operands.
- req_ready  out  NUM_REQ  one-hot; request i accepted this cycle.
- req_a  in  NUM_REQ*9  operand a; requester i at bits [9i+8:9i].
- req_b  in  NUM_REQ*9  operand b; same packing as req_a.
- rsp_valid  out  NUM_REQ  one-hot; product ready for requester i.
- rsp_ready  in  NUM_REQ  requester i accepts product.
- rsp_y  out  18  product, shared by all requesters.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, grant=0, operand regs=0, rsp_y=0.
  - req_ready=0, rsp_valid=0.
  - Any in-flight op is dropped.
- Arithmetic: unsigned; y = a*b. Maximum 511*511 = 261121 fits in 18 bits, so no overflow handling.
- IDLE:
  - If any req_valid: winner g = first set bit searching from ptr upward, wrapping at NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle. req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
  - On the clock edge: op_a<=req_a[g], op_b<=req_b[g], grant<=g, state<=CALC.
  - With no req_valid: stay in IDLE, req_ready=0.
- CALC:
  - op_a/op_b drive the multiplier.
  - On the edge: rsp_y<=y, state<=RESP.
  - req_ready=0.
- RESP:
  - rsp_valid[grant]=1; rsp_y is held stable.
  - When rsp_ready[grant]=1: ptr<=(grant+1) mod NUM_REQ, state<=IDLE.
  - rsp_ready on non-granted bits is ignored.
- Latency: accept at edge T; rsp_valid high during cycle T+2.
- Throughput: at most one op per 3 cycles, plus any response stall.
- Stalls and boundary cases:
  - During CALC/RESP, all req_ready=0; pending requests wait. req_valid changes in these states have no effect.
  - req_valid dropped in the same cycle it was granted: the grant still completes, because acceptance is the edge with req_ready=1 and valid=1.
  - rsp_y keeps its last value after the handshake until the next capture.
  - Only one op is outstanding; no buffering.
- Reset mid-operation (any state): immediate return to reset values; no response is produced for the dropped op.

Optional Feature:
- Macro: MULT_SHARE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. ptr is tied to 0 and never updated.
- Undefined (default): round-robin as above.

Decomposition:
- Package mult_share_arb_pkg:
  - Constants A_W=9, B_W=9, Y_W=18.
  - typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t.
- Sub-module mult_rr_grant: combinational one-hot winner from req_valid and ptr. It contains the fixed-priority variant under the macro.
- The top level instantiates the existing `multiplier` (9,9 -> 18) once.

Test Plan:
- Single op: after reset, req 0 with a=2, b=2 -> req_ready[0]=1 at cycle T, rsp_valid[0]=1 at T+2, rsp_y=4.
- Contention: all 4 valid from reset, a_i=i+1, b=3, rsp_ready=1 -> served order 0,1,2,3 with rsp_y 3, 6, 9, 12 on rsp_valid bits 0..3, one op every 3 cycles.
- Backpressure: req 1 with a=4, b=4, rsp_ready[1]=0 for 5 cycles, other reqs valid -> rsp_valid[1] stays 1, rsp_y=16 stable, all req_ready=0 until rsp_ready[1]=1.
- Max operands: a=511, b=511 -> rsp_y=261121.
- Fairness: reqs 0 and 2 continuously valid -> grants alternate 0,2,0,2. With MULT_SHARE_ARB_FIXED_PRIO_EN, grants are 0,0,0.
- Reset mid-op: rst_n=0 during CALC -> outputs 0 immediately and no response. After release, req 2 with 7*9 -> rsp_valid[2], rsp_y=63, and ptr restarts at 0.
